n_set_cache_victim_requester: RTL
=================================

Name: n_set_cache_victim_requester

Overview:
- Cache-side initiator for the n-set replacement policy interface.
- On a core miss, selects a victim block address. The lowest invalid way of the target set is used first. If every way is valid, the block pulses the policy controller's miss input and captures the replacement address the controller returns.
- Then sequences an optional dirty writeback and the line fill, and reports completion to the cache controller.
- Cache block address format is {way, set}: set in the low BW_SET bits, way in the high BW_WAY bits.

Parameters:
- CACHE_BLOCK_CAPACITY, 128, total cache blocks (power of 2); BW_CACHE_CAPACITY = clog2 of this.
- CACHE_SET_SIZE, 4, ways per set (power of 2); BW_WAY = clog2(CACHE_SET_SIZE).
- BW_SET is derived as BW_CACHE_CAPACITY - BW_WAY. When BW_SET = 0 (fully associative), the address is way only.

Ports:
- clock_i  in  1  clock; all state updates on the rising edge.
- resetn_i  in  1  asynchronous, active-low reset.
- hit_i  in  1  core hit strobe.
- hit_addr_i  in  BW_CACHE_CAPACITY  block address of the hit.
- miss_i  in  1  single-cycle core miss strobe; only legal when busy_o=0.
- miss_set_i  in  max(BW_SET,1)  set index of the miss; ignored when BW_SET=0.
- valid_i  in  CACHE_SET_SIZE  valid bit per way of the miss set; valid in the cycle after miss_i.
- dirty_i  in  CACHE_SET_SIZE  dirty bit per way of the miss set; valid in the cycle after miss_i.
- policy_hit_o  out  1  forwarded hit strobe to the policy controller.
- policy_miss_o  out  1  one-cycle replacement request pulse to the policy controller.
- policy_addr_o  out  BW_CACHE_CAPACITY  hit address or {0, miss set}, sent to the policy controller.
- policy_done_i  in  1  policy controller replacement address valid.
- policy_addr_i  in  BW_CACHE_CAPACITY  replacement address from the policy controller.
- wb_req_o  out  1  writeback request; held high until wb_ack_i.
- wb_ack_i  in  1  writeback complete.
- fill_req_o  out  1  fill request; held high until fill_ack_i.
- fill_ack_i  in  1  fill complete.
- victim_addr_o  out  BW_CACHE_CAPACITY  selected victim block address; stable from the end of SELECT until the next miss.
- busy_o  out  1  high in every state except IDLE.
- done_o  out  1  one-cycle completion pulse.

Behaviour:
- Reset: all outputs are 0, state is IDLE, latched vectors and addresses are cleared.
- Reset asserted mid-operation aborts immediately. Outstanding wb/fill requests drop to 0 and no done_o is issued.
- Hit forwarding: policy_hit_o and policy_addr_o are registered copies of hit_i and hit_addr_i (1-cycle latency), in any state. A hit never perturbs the FSM.
- If a hit and a policy request coincide, the request owns policy_addr_o and the hit strobe is still forwarded.
- IDLE: on miss_i, latch miss_set_i and go to SCAN. miss_i while busy_o=1 is ignored.
- SCAN (1 cycle): latch valid_i and dirty_i.
  - If any valid bit is 0: victim way = lowest-index invalid way, victim clean. Go to SELECT; the policy controller is not pulsed.
  - Otherwise: go to REQ.
- REQ (1 cycle): policy_miss_o=1 and policy_addr_o={0, set}. Go to WAIT.
- WAIT: policy_done_i is first sampled in the cycle after REQ, never in REQ itself.
  - On the first sampled policy_done_i=1, take victim way = policy_addr_i[BW_CACHE_CAPACITY-1:BW_SET] and go to SELECT.
  - The set bits of policy_addr_i are ignored; the latched set is authoritative.
  - No timeout.
- SELECT (1 cycle): victim_addr_o = {way, set}.
  - Next state is WB if the latched dirty bit of that way is 1 and it was valid; otherwise FILL.
- WB: wb_req_o=1 until wb_ack_i is sampled high. The same edge clears wb_req_o and enters FILL.
- FILL: fill_req_o=1 until fill_ack_i is sampled high. The same edge clears fill_req_o and enters DONE.
- DONE (1 cycle): done_o=1, then IDLE. busy_o falls in the same cycle the FSM returns to IDLE.
- An ack arriving outside its own state is ignored.
- Minimum miss-to-done latency:
  - invalid-way path, clean: 5 cycles with acks returned immediately.
  - policy path: +2 cycles.
  - dirty: +1 cycle.

Test Plan:
1. Defaults; after reset, miss_i with set=5, valid_i=4'b1011 -> no policy_miss_o; victim_addr_o={2'd2, 5'd5}=7'h45; wb_req_o never asserted; fill_req_o asserted; done_o 1 cycle after fill_ack_i.
2. set=3, valid=4'hF, dirty=4'b0010, policy returns addr 7'h23 with done_i one cycle after pulse -> exactly one policy_miss_o with policy_addr_o=7'h03; victim_addr_o=7'h23; wb_req_o then fill_req_o; done_o once.
3. Same as 2 but policy_addr_i=7'h7F (set bits 31) -> victim_addr_o=7'h63; latched set wins.
4. hit_i with hit_addr_i=7'h11 during WB and during WAIT -> policy_hit_o=1 with policy_addr_o=7'h11 one cycle later; FSM state and victim unchanged.
5. miss_i pulsed again while in FILL -> ignored; only one done_o; a miss issued the cycle after done_o is accepted.
6. resetn_i low while wb_req_o=1 -> wb_req_o, busy_o and victim_addr_o go to 0 asynchronously; after release a fresh miss completes normally.

Source files
------------

// File: rtl/n_set_cache_victim_requester.sv
// Cache-side victim requester for the n-set replacement policy interface.
// On a core miss it picks the lowest invalid way of the set. If every way is
// valid it asks the policy controller instead. It then runs an optional dirty
// writeback and the line fill, and pulses done_o when the fill completes.
// Block address format is {way, set}.
module n_set_cache_victim_requester #(
  parameter int CACHE_BLOCK_CAPACITY = 128,
  parameter int CACHE_SET_SIZE       = 4,
  localparam int BW_CACHE_CAPACITY   = $clog2(CACHE_BLOCK_CAPACITY),
  localparam int BW_WAY              = $clog2(CACHE_SET_SIZE),
  localparam int BW_SET              = BW_CACHE_CAPACITY - BW_WAY,
  localparam int BW_SET_PORT         = (BW_SET > 0) ? BW_SET : 1
) (
  input  logic                         clock_i,
  input  logic                         resetn_i,
  input  logic                         hit_i,
  input  logic [BW_CACHE_CAPACITY-1:0] hit_addr_i,
  input  logic                         miss_i,
  input  logic [BW_SET_PORT-1:0]       miss_set_i,
  input  logic [CACHE_SET_SIZE-1:0]    valid_i,
  input  logic [CACHE_SET_SIZE-1:0]    dirty_i,
  output logic                         policy_hit_o,
  output logic                         policy_miss_o,
  output logic [BW_CACHE_CAPACITY-1:0] policy_addr_o,
  input  logic                         policy_done_i,
  input  logic [BW_CACHE_CAPACITY-1:0] policy_addr_i,
  output logic                         wb_req_o,
  input  logic                         wb_ack_i,
  output logic                         fill_req_o,
  input  logic                         fill_ack_i,
  output logic [BW_CACHE_CAPACITY-1:0] victim_addr_o,
  output logic                         busy_o,
  output logic                         done_o
);

  localparam int WW = (BW_WAY > 0) ? BW_WAY : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN,
    S_REQ,
    S_WAIT,
    S_SELECT,
    S_WB,
    S_FILL,
    S_DONE
  } state_t;

  state_t                         state_q;
  logic [BW_SET_PORT-1:0]         set_q;
  logic [CACHE_SET_SIZE-1:0]      valid_q;
  logic [CACHE_SET_SIZE-1:0]      dirty_q;
  logic [WW-1:0]                  way_q;
  logic [BW_CACHE_CAPACITY-1:0]   victim_q;
  logic                           policy_hit_q;
  logic                           policy_miss_q;
  logic [BW_CACHE_CAPACITY-1:0]   policy_addr_q;
  logic                           wb_req_q;
  logic                           fill_req_q;
  logic                           busy_q;
  logic                           done_q;

  logic [WW-1:0]                  scan_way_d;
  logic [WW-1:0]                  policy_way_d;
  logic [BW_CACHE_CAPACITY-1:0]   set_ext_d;
  logic [BW_CACHE_CAPACITY-1:0]   victim_d;

  // Lowest-index invalid way of the incoming valid vector (descending scan so the lowest wins).
  always_comb begin
    scan_way_d = '0;
    for (int unsigned i = CACHE_SET_SIZE; i > 0; i--) begin
      if (!valid_i[i-1]) scan_way_d = WW'(i - 1);
    end
  end

  // Address helpers: zero-extended set, way field of the policy reply, assembled victim.
  always_comb begin
    set_ext_d = '0;
    if (BW_SET > 0) set_ext_d = BW_CACHE_CAPACITY'(set_q);
    policy_way_d = WW'(policy_addr_i >> BW_SET);
    victim_d     = (BW_CACHE_CAPACITY'(way_q) << BW_SET) | set_ext_d;
  end

  // Miss sequencing FSM with registered outputs; hit forwarding runs alongside in every state.
  always_ff @(posedge clock_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q       <= S_IDLE;
      set_q         <= '0;
      valid_q       <= '0;
      dirty_q       <= '0;
      way_q         <= '0;
      victim_q      <= '0;
      policy_hit_q  <= 1'b0;
      policy_miss_q <= 1'b0;
      policy_addr_q <= '0;
      wb_req_q      <= 1'b0;
      fill_req_q    <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      policy_hit_q  <= hit_i;
      policy_addr_q <= hit_addr_i;
      policy_miss_q <= 1'b0;
      done_q        <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (miss_i) begin
            set_q   <= miss_set_i;
            busy_q  <= 1'b1;
            state_q <= S_SCAN;
          end
        end
        S_SCAN: begin
          valid_q <= valid_i;
          dirty_q <= dirty_i;
          if (!(&valid_i)) begin
            way_q   <= scan_way_d;
            state_q <= S_SELECT;
          end else begin
            // The request owns the policy address bus over a coincident hit.
            policy_miss_q <= 1'b1;
            policy_addr_q <= set_ext_d;
            state_q       <= S_REQ;
          end
        end
        S_REQ: begin
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (policy_done_i) begin
            way_q   <= policy_way_d;
            state_q <= S_SELECT;
          end
        end
        S_SELECT: begin
          victim_q <= victim_d;
          if (dirty_q[way_q] && valid_q[way_q]) begin
            wb_req_q <= 1'b1;
            state_q  <= S_WB;
          end else begin
            fill_req_q <= 1'b1;
            state_q    <= S_FILL;
          end
        end
        S_WB: begin
          if (wb_ack_i) begin
            wb_req_q   <= 1'b0;
            fill_req_q <= 1'b1;
            state_q    <= S_FILL;
          end
        end
        S_FILL: begin
          if (fill_ack_i) begin
            fill_req_q <= 1'b0;
            done_q     <= 1'b1;
            state_q    <= S_DONE;
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Output ports are the registered state directly.
  always_comb begin
    policy_hit_o  = policy_hit_q;
    policy_miss_o = policy_miss_q;
    policy_addr_o = policy_addr_q;
    wb_req_o      = wb_req_q;
    fill_req_o    = fill_req_q;
    victim_addr_o = victim_q;
    busy_o        = busy_q;
    done_o        = done_q;
  end

endmodule
